// File: rtl/iomem_ledpwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iomem_ledpwm_pkg
// Description : Shared register map, CTRL field positions and helpers for
//               the iomem LED PWM controller.
// Revision    : 1.0 - initial release
// ============================================================================
package iomem_ledpwm_pkg;

  // Register offsets, taken from iomem_addr[3:2]
  typedef enum logic [1:0] {
    CTRL    = 2'd0,
    DUTY_LO = 2'd1,
    DUTY_HI = 2'd2,
    STATUS  = 2'd3
  } reg_off_e;

  // CTRL field positions
  localparam int EN_BIT    = 0;
  localparam int PRESC_LSB = 8;
  localparam int PRESC_MSB = 15;

  // Number of PWM channels
  localparam int NUM_CH = 8;

  // Merge a 32-bit write into an existing word, byte by byte under strobe
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iomem_ledpwm_timebase.sv
`default_nettype none
// ============================================================================
// Module      : pwm_timebase
// Description : Prescaler and 8-bit phase counter for the LED PWM. Emits a
//               tick every PRESC+1 cycles and a wrap strobe on the tick that
//               takes the phase from 255 back to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_timebase (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic [7:0] presc,
  input  logic       clr,
  output logic       tick,
  output logic [7:0] phase,
  output logic       wrap
);

  logic [7:0] pre_cnt_q, pre_cnt_d;
  logic [7:0] phase_q, phase_d;

  // Next-state for prescaler and phase; both are parked at 0 while disabled.
  // A prescaler clear only restarts the divider; a tick already due in this
  // cycle still advances the phase.
  always_comb begin
    tick      = en && (pre_cnt_q == presc);
    wrap      = tick && (phase_q == 8'hFF);
    pre_cnt_d = pre_cnt_q;
    phase_d   = phase_q;
    if (!en) begin
      pre_cnt_d = 8'd0;
      phase_d   = 8'd0;
    end else begin
      if (tick) begin
        pre_cnt_d = 8'd0;
        phase_d   = phase_q + 8'd1;
      end else begin
        pre_cnt_d = pre_cnt_q + 8'd1;
      end
      if (clr) pre_cnt_d = 8'd0;
    end
  end

  // Counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pre_cnt_q <= 8'd0;
      phase_q   <= 8'd0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      phase_q   <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule
`default_nettype wire

// File: rtl/iomem_ledpwm.sv
`default_nettype none
// ============================================================================
// Module      : iomem_ledpwm
// Description : Memory-mapped 8-channel LED PWM on the PicoSoC iomem bus.
//               Bus decode, CTRL/shadow/active duty registers and per-channel
//               comparators. Shadow duties move to the active set at the
//               period wrap (or continuously while disabled).
// Revision    : 1.0 - initial release
// ============================================================================
module iomem_ledpwm
  import iomem_ledpwm_pkg::*;
#(
  parameter logic [7:0] ADDR_HI = 8'h04
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic [7:0]  leds
);

  logic                     ready_q;
  logic [31:0]              rdata_q, rdata_d;
  logic                     en_q, en_d;
  logic [7:0]               presc_q, presc_d;
  logic [NUM_CH-1:0][7:0]   shadow_q, shadow_d;
  logic [NUM_CH-1:0][7:0]   active_q, active_d;
  logic [NUM_CH-1:0]        leds_q, leds_d;

  logic                     sel;
  logic                     wr;
  logic                     clr;
  reg_off_e                 off;
  logic [7:0]               phase;
  logic                     wrap;
  logic                     unused_tick;
  logic                     unused_addr;

  // Address bits outside the window select and register offset are don't-care
  assign unused_addr = ^{iomem_addr[23:4], iomem_addr[1:0]};

  // The !ready_q term keeps a held request from being acked twice in a row
  assign sel = iomem_valid && !ready_q && (iomem_addr[31:24] == ADDR_HI);
  assign wr  = sel && (iomem_wstrb != 4'b0000);
  assign off = reg_off_e'(iomem_addr[3:2]);

  // Bus decode: read mux and byte-strobed register writes
  always_comb begin
    rdata_d  = rdata_q;
    en_d     = en_q;
    presc_d  = presc_q;
    shadow_d = shadow_q;
    clr      = 1'b0;
    if (sel) begin
      case (off)
        CTRL:    rdata_d = {16'd0, presc_q, 7'd0, en_q};
        DUTY_LO: rdata_d = shadow_q[3:0];
        DUTY_HI: rdata_d = shadow_q[7:4];
        STATUS:  rdata_d = {23'd0, en_q, phase};
        default: rdata_d = 32'd0;
      endcase
    end
    if (wr) begin
      case (off)
        CTRL: begin
          if (iomem_wstrb[0]) en_d = iomem_wdata[EN_BIT];
          if (iomem_wstrb[1]) begin
            presc_d = iomem_wdata[PRESC_MSB:PRESC_LSB];
            clr     = 1'b1;
          end
        end
        DUTY_LO: shadow_d[3:0] = byte_merge(shadow_q[3:0], iomem_wdata, iomem_wstrb);
        DUTY_HI: shadow_d[7:4] = byte_merge(shadow_q[7:4], iomem_wdata, iomem_wstrb);
        default: ;  // STATUS is read-only: write is acked and dropped
      endcase
    end
  end

  // Active duties track the shadow while disabled and latch it at each wrap.
  // Using shadow_q means a write landing on the wrap cycle waits one period.
  always_comb begin
    active_d = active_q;
    if (!en_q || wrap) active_d = shadow_q;
  end

  // One comparator per channel; output is registered below
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign leds_d[i] = en_q && (phase < active_q[i]);
  end

  // Register bank with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q  <= 1'b0;
      rdata_q  <= 32'd0;
      en_q     <= 1'b0;
      presc_q  <= 8'd0;
      shadow_q <= '0;
      active_q <= '0;
      leds_q   <= '0;
    end else begin
      ready_q  <= sel;
      rdata_q  <= rdata_d;
      en_q     <= en_d;
      presc_q  <= presc_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      leds_q   <= leds_d;
    end
  end

  pwm_timebase u_timebase (
    .clk    (clk),
    .resetn (resetn),
    .en     (en_q),
    .presc  (presc_q),
    .clr    (clr),
    .tick   (unused_tick),
    .phase  (phase),
    .wrap   (wrap)
  );

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign leds        = leds_q;

endmodule
`default_nettype wire

// File: tb/tb_iomem_ledpwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_iomem_ledpwm
// Description : Self-checking bench for iomem_ledpwm. Bus reads push their
//               expected data into a scoreboard queue; a monitor pops and
//               compares on every ack. Timebase phase is predicted by a small
//               cycle-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iomem_ledpwm;

  logic        clk;
  logic        resetn;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [7:0]  leds;

  typedef struct {
    logic [31:0] exp;
    bit          cmp;
  } sb_t;

  sb_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Phase model: phase after edge n = base_phase + (n-base_edge)/(presc_m+1)
  int base_edge  = 0;
  int base_phase = 0;
  int presc_m    = 0;
  bit en_m       = 0;

  bit prev_ready = 0;
  int cnt[8];
  int cnt_a, cnt_b, rise_a, rise_b;
  logic prev_led;

  iomem_ledpwm #(.ADDR_HI(8'h04)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .leds        (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] phase_at(input int n);
    return 8'(base_phase + (n - base_edge) / (presc_m + 1));
  endfunction

  // Scoreboard consumer: every ack pops one entry
  always @(negedge clk) begin
    if (iomem_ready) begin
      check("ready_pulse", {31'd0, prev_ready}, 32'd0);
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (e.cmp) check("rdata", iomem_rdata, e.exp);
      end
    end
    prev_ready = iomem_ready;
  end

  // One bus transaction; STATUS expectations come from the phase model
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] exp, input bit cmp, input bit want_ack,
                     input bit is_status);
    int   cycles;
    bit   acked;
    sb_t  e;
    @(posedge clk); #1;
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wdata = d;
    iomem_wstrb = s;
    e.exp = is_status ? {23'd0, en_m, (en_m ? phase_at(cyc) : 8'd0)} : exp;
    e.cmp = cmp;
    if (want_ack) sb_q.push_back(e);
    cycles = 0;
    acked  = 0;
    while (!acked && cycles < 6) begin
      @(posedge clk); #1;
      cycles++;
      if (iomem_ready) acked = 1;
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    if (want_ack) check("ack_latency", 32'(cycles), 32'd1);
    else          check("no_ack", {31'd0, acked}, 32'd0);
  endtask

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn      = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;

    // Reset
    repeat (4) @(posedge clk);
    #1;
    check("rst_leds",  {24'd0, leds}, 32'd0);
    check("rst_ready", {31'd0, iomem_ready}, 32'd0);
    check("rst_rdata", iomem_rdata, 32'd0);
    resetn = 1'b1;
    bus(32'h0400000C, 0, 4'h0, 0, 1, 1, 1);

    // Register R/W
    bus(32'h04000004, 32'h80402010, 4'hF, 0, 0, 1, 0);
    bus(32'h04000004, 0, 4'h0, 32'h80402010, 1, 1, 0);
    bus(32'h04000004, 32'h00FF0000, 4'h4, 0, 0, 1, 0);
    bus(32'h04000004, 0, 4'h0, 32'h80FF2010, 1, 1, 0);

    // Address decode and aliasing
    bus(32'h03000004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
    bus(32'h04000004, 0, 4'h0, 32'h80FF2010, 1, 1, 0);
    bus(32'h04000010, 32'hFFFFABFE, 4'hF, 0, 0, 1, 0);
    bus(32'h04000000, 0, 4'h0, 32'h0000AB00, 1, 1, 0);
    bus(32'h04000008, 32'h12345678, 4'h0, 32'h00000000, 1, 1, 0);
    bus(32'h04000008, 0, 4'h0, 32'h00000000, 1, 1, 0);
    bus(32'h0400000C, 32'hFFFFFFFF, 4'hF, 0, 0, 1, 0);
    bus(32'h04000000, 0, 4'h0, 32'h0000AB00, 1, 1, 0);

    // PWM duty at PRESC=0
    bus(32'h04000004, 32'hFF800100, 4'hF, 0, 0, 1, 0);
    bus(32'h04000008, 32'h40C00210, 4'hF, 0, 0, 1, 0);
    bus(32'h04000000, 32'h00000001, 4'hF, 0, 0, 1, 0);
    en_m = 1; base_edge = cyc; base_phase = 0; presc_m = 0;
    repeat (10) @(posedge clk);
    for (int c = 0; c < 8; c++) cnt[c] = 0;
    repeat (256) begin
      @(negedge clk);
      for (int c = 0; c < 8; c++) cnt[c] += int'(leds[c]);
    end
    check("duty0", 32'(cnt[0]), 32'd0);
    check("duty1", 32'(cnt[1]), 32'd1);
    check("duty2", 32'(cnt[2]), 32'd128);
    check("duty3", 32'(cnt[3]), 32'd255);
    check("duty4", 32'(cnt[4]), 32'd16);
    check("duty5", 32'(cnt[5]), 32'd2);
    check("duty6", 32'(cnt[6]), 32'd192);
    check("duty7", 32'(cnt[7]), 32'd64);
    bus(32'h0400000C, 0, 4'h0, 0, 1, 1, 1);

    // Double buffer: duty0 64 -> 192 written at phase 100
    bus(32'h04000004, 32'h00000040, 4'h1, 0, 0, 1, 0);
    repeat (260) @(posedge clk);
    #1;
    while (phase_at(cyc) != 8'd0) begin
      @(posedge clk); #1;
    end
    cnt_a = 0; cnt_b = 0; rise_a = 0; rise_b = 0;
    prev_led = leds[0];
    fork
      begin
        for (int i = 0; i < 512; i++) begin
          @(posedge clk);
          @(negedge clk);
          if (i < 256) begin
            cnt_a += int'(leds[0]);
            if (leds[0] && !prev_led) rise_a++;
          end else begin
            cnt_b += int'(leds[0]);
            if (leds[0] && !prev_led) rise_b++;
          end
          prev_led = leds[0];
        end
      end
      begin
        repeat (99) @(posedge clk);
        bus(32'h04000004, 32'h000000C0, 4'h1, 0, 0, 1, 0);
      end
    join
    check("dbuf_cur",  32'(cnt_a), 32'd64);
    check("dbuf_next", 32'(cnt_b), 32'd192);
    check("dbuf_rise_cur",  32'(rise_a), 32'd1);
    check("dbuf_rise_next", 32'(rise_b), 32'd1);

    // Prescaler = 3
    bus(32'h04000000, 32'h00000301, 4'hF, 0, 0, 1, 0);
    base_phase = int'(phase_at(cyc)); base_edge = cyc; presc_m = 3;
    repeat (4) bus(32'h0400000C, 0, 4'h0, 0, 1, 1, 1);
    repeat (2) @(posedge clk);
    bus(32'h04000000, 32'h00000301, 4'h2, 0, 0, 1, 0);
    base_phase = int'(phase_at(cyc)); base_edge = cyc;
    repeat (5) bus(32'h0400000C, 0, 4'h0, 0, 1, 1, 1);
    repeat (1024) @(posedge clk);
    repeat (2) bus(32'h0400000C, 0, 4'h0, 0, 1, 1, 1);

    // Reset returns everything to zero
    @(posedge clk); #1;
    resetn = 1'b0;
    en_m   = 0;
    @(posedge clk); #1;
    check("rst2_leds",  {24'd0, leds}, 32'd0);
    check("rst2_rdata", iomem_rdata, 32'd0);
    resetn = 1'b1;
    bus(32'h04000004, 0, 4'h0, 32'h00000000, 1, 1, 0);
    bus(32'h0400000C, 0, 4'h0, 0, 1, 1, 1);

    repeat (2) @(posedge clk);
    check("sb_left", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
